uart_tx_async: RTL and testbench
================================

# uart_tx_async

Asynchronous UART transmitter, the transmit-side counterpart of the CoreUART receive path. It takes bytes from the APB-side register block through a one-deep holding register and serialises them on the TX pin. Frames are start bit, 7 or 8 data bits LSB first, optional even/odd parity, and 1 or 2 stop bits. Bit timing comes from the shared 16x baud enable, so TX and RX share one baud generator.

## Interface
Parameters:
- STOP_BITS, 1, number of stop bits (legal values 1 or 2; any other value is treated as 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- baud_clock  in  1  one-clk-wide enable pulse at 16x the bit rate.
- bit8  in  1  1 selects 8 data bits, 0 selects 7 (bit 7 of the data is ignored).
- parity_en  in  1  1 appends a parity bit.
- odd_n_even  in  1  1 selects odd parity, 0 selects even.
- tx_hold_reg  in  8  byte to transmit.
- webhr  in  1  write strobe for the holding register.
- txrdy  out  1  holding register empty; a write is accepted.
- tx_busy  out  1  a frame is on the line (state is not IDLE).
- tx  out  1  serial output; idle level is 1.

## Operation
- Reset values: txrdy=1, tx_busy=0, tx=1, FSM=IDLE, tick counter=0, bit counter=0, holding and shift registers=0x00.
- Holding register:
  - webhr with txrdy=1 latches tx_hold_reg and clears txrdy on the next edge.
  - webhr with txrdy=0 is ignored: the data is dropped and nothing is flagged.
- Load: in IDLE, or at the end of the last STOP tick, with the holding register full and baud_clock=1:
  - copy holding to shift register, snapshot bit8/parity_en/odd_n_even, set txrdy=1, enter START.
  - Configuration changes mid-frame have no effect until the next load.
- Tick counter: 4 bits, advances only on baud_clock. Each bit period is exactly 16 baud ticks. The state advances on the baud tick where the counter wraps 15->0.
- FSM states:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right once per bit; 8 or 7 bits counted by the bit counter.
  - PARITY (only if parity_en snapshot): tx = XOR of sent data bits for even, inverted for odd.
  - STOP: tx=1 for 16*STOP_BITS ticks, then go to START if the holding register is full (back-to-back), else IDLE.
- Parity is accumulated serially; 7-bit mode covers bits 6:0 only.
- tx is registered (no combinational path from FSM to pin).
- Reset asserted mid-frame aborts immediately: tx=1, txrdy=1, and the holding contents are lost.

## Timing
- webhr at edge N gives txrdy=0 after edge N.
- The load tick at edge M gives tx=0 and txrdy=1 after edge M.
- Frame lengths in baud ticks:
  - 8N1: 160 (10 bits x 16).
  - 8E1: 176.
  - 7N2 with STOP_BITS=2: 160.
- Back-to-back frames: the START of frame 2 begins on the tick right after the last STOP tick of frame 1, with no idle gap.
- webhr and a load on the same edge cannot conflict: a load requires txrdy=0, and a write requires txrdy=1.
- The baud_clock period may be 1 clk; the block must work with baud_clock tied high.

## Configuration
- UART_TX_BREAK_EN defined:
  - adds input port break_en (1 bit).
  - While break_en=1, tx is forced to 0 regardless of state, and the FSM keeps running.
  - When break_en falls, tx resumes the FSM value on the next edge.
  - A frame sent during break is corrupted by design.
- Undefined: no break_en port; tx is driven only by the FSM.

## Structure
- Shared package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - TICKS_PER_BIT=16 and the tick counter width; the receive path imports the same constants.
- One sub-module, uart_baud_tick_cnt: the 4-bit counter with baud_clock enable, synchronous clear, and a wrap output. It is reusable by the receive path.

## Test plan
- 8N1, baud_clock=1, write 0x55:
  - tx=0 for 16 clk.
  - Then 1,0,1,0,1,0,1,0 (16 clk each).
  - Then 1 for 16 clk; txrdy high 1 clk after the load.
- 8-bit even parity, write 0xA3: data bits 1,1,0,0,0,1,0,1, parity bit 0. With odd_n_even=1 the parity bit is 1.
- 7-bit, no parity, write 0xFF: seven 1 data bits, then stop. The frame is 9 bits (144 ticks) and bit 7 is never sent.
- Back-to-back:
  - Write 0x01, then 0x02 once txrdy returns to 1.
  - The START of 0x02 follows the STOP of 0x01 with no gap.
  - A third write while txrdy=0 is dropped.
- Assert reset_n low in the middle of the DATA state: tx=1 and txrdy=1 asynchronously. After release the FSM sits in IDLE, tx stays 1, and nothing is transmitted.
- UART_TX_BREAK_EN build:
  - break_en=1 during a 0xFF frame holds tx=0 throughout.
  - Release before the stop bit makes the stop bit 1.
  - txrdy and FSM timing are unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared UART constants and transmit state encoding.                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam int TICK_CNT_W    = $clog2(TICKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_tick_cnt                                                   |
// | Bit-period tick counter on the 16x baud enable, with wrap strobe.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_baud_tick_cnt
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam logic [TICK_CNT_W-1:0] c_last = TICK_CNT_W'(TICKS_PER_BIT - 1);

    logic [TICK_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Wrap marks the last tick of a bit period; the counter rolls to 0 itself.
    assign wrap = en && !clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_async.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_async                                                        |
// | UART transmitter: one-deep holding register, 7/8 data bits, optional |
// | parity, 1/2 stop bits. Define UART_TX_BREAK_EN to add break_en.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_async
    import uart_pkg::*;
#(
    parameter int STOP_BITS = 1
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic [7:0] tx_hold_reg,
    input  logic       webhr,
`ifdef UART_TX_BREAK_EN
    input  logic       break_en,
`endif
    output logic       txrdy,
    output logic       tx_busy,
    output logic       tx
);

    localparam logic [2:0] c_last_stop = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    tx_state_t  r_state, w_state_nxt;
    logic [7:0] r_hold;
    logic [7:0] r_shift, w_shift_nxt;
    logic [2:0] r_bitcnt, w_bitcnt_nxt;
    logic       r_par, w_par_nxt;
    logic       r_bit8, r_par_en;
    logic       r_txrdy;
    logic       r_tx, w_tx_nxt;
    logic       w_load;
    logic       w_wrap;
    logic       w_tick_clr;

    assign w_tick_clr = (r_state == IDLE);

    uart_baud_tick_cnt u_tick_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (baud_clock),
        .clr     (w_tick_clr),
        .wrap    (w_wrap)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_par_nxt    = r_par;
        w_load       = 1'b0;
        w_tx_nxt     = 1'b1;

        case (r_state)
            IDLE: begin
                if (baud_clock && !r_txrdy) w_load = 1'b1;
            end
            START: begin
                if (w_wrap) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_wrap) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_par_nxt   = r_par ^ r_shift[0];
                    if (r_bitcnt == (r_bit8 ? 3'd7 : 3'd6)) begin
                        w_bitcnt_nxt = 3'd0;
                        w_state_nxt  = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_wrap) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_wrap) begin
                    if (r_bitcnt == c_last_stop) begin
                        if (!r_txrdy) w_load = 1'b1;
                        else          w_state_nxt = IDLE;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Parity seeds with the odd/even select so the final value needs no fix-up.
        if (w_load) begin
            w_state_nxt  = START;
            w_shift_nxt  = r_hold;
            w_bitcnt_nxt = 3'd0;
            w_par_nxt    = odd_n_even;
        end

        // The pin is registered from the next-state view so it changes with the state.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = w_par_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_par    <= 1'b0;
            r_bit8   <= 1'b0;
            r_par_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_par    <= w_par_nxt;
            if (w_load) begin
                r_bit8   <= bit8;
                r_par_en <= parity_en;
            end
        end
    end

    // A load needs txrdy=0 and a write needs txrdy=1, so the two never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold  <= 8'h00;
            r_txrdy <= 1'b1;
        end else if (w_load) begin
            r_txrdy <= 1'b1;
        end else if (webhr && r_txrdy) begin
            r_hold  <= tx_hold_reg;
            r_txrdy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx <= 1'b1;
        end else begin
`ifdef UART_TX_BREAK_EN
            r_tx <= break_en ? 1'b0 : w_tx_nxt;
`else
            r_tx <= w_tx_nxt;
`endif
        end
    end

    assign txrdy   = r_txrdy;
    assign tx_busy = (r_state != IDLE);
    assign tx      = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_async.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_async                                                     |
// | Self-checking bench: frame-level tick model plus directed literals.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_tx_async;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_clock = 1'b1;
    logic       bit8 = 1'b1;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
    logic [7:0] tx_hold_reg = 8'h00;
    logic       webhr = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic       break_en = 1'b0;
`endif
    logic       txrdy, tx_busy, tx;
    logic       txrdy2, busy2, tx2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    uart_tx_async #(.STOP_BITS(1)) dut (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .bit8(bit8),
        .parity_en(parity_en), .odd_n_even(odd_n_even), .tx_hold_reg(tx_hold_reg),
        .webhr(webhr),
`ifdef UART_TX_BREAK_EN
        .break_en(break_en),
`endif
        .txrdy(txrdy), .tx_busy(tx_busy), .tx(tx)
    );

    uart_tx_async #(.STOP_BITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .bit8(bit8),
        .parity_en(parity_en), .odd_n_even(odd_n_even), .tx_hold_reg(tx_hold_reg),
        .webhr(webhr),
`ifdef UART_TX_BREAK_EN
        .break_en(break_en),
`endif
        .txrdy(txrdy2), .tx_busy(busy2), .tx(tx2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the STOP_BITS=1 instance: each frame becomes a queue of per-tick line levels.
    bit         m_wave[$];
    logic [7:0] m_hold = 8'h00;
    bit         m_full = 1'b0;
    bit         m_tx   = 1'b1;

    task automatic load_frame(input logic [7:0] d, input bit b8, input bit pe, input bit odd);
        bit bits[$];
        int nb;
        bit p;
        nb = b8 ? 8 : 7;
        p  = odd ^ (b8 ? (^d) : (^d[6:0]));
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(p);
        bits.push_back(1'b1);
        m_wave.delete();
        foreach (bits[i])
            for (int k = 0; k < 16; k++) m_wave.push_back(bits[i]);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_wave.delete();
                m_full = 1'b0;
                m_hold = 8'h00;
                m_tx   = 1'b1;
            end else begin
                bit full_pre;
                bit brk;
                full_pre = m_full;
`ifdef UART_TX_BREAK_EN
                brk = break_en;
`else
                brk = 1'b0;
`endif
                if (baud_clock) begin
                    if (m_wave.size() > 0) void'(m_wave.pop_front());
                    if (m_wave.size() == 0 && full_pre) begin
                        load_frame(m_hold, bit8, parity_en, odd_n_even);
                        m_full = 1'b0;
                    end
                end
                if (webhr && !full_pre) begin
                    m_hold = tx_hold_reg;
                    m_full = 1'b1;
                end
                m_tx = brk ? 1'b0 : ((m_wave.size() > 0) ? m_wave[0] : 1'b1);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_tx",    {31'd0, tx},      {31'd0, m_tx});
            check("cyc_txrdy", {31'd0, txrdy},   {31'd0, !m_full});
            check("cyc_busy",  {31'd0, tx_busy}, {31'd0, (m_wave.size() > 0)});
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic cfg(input bit b8, input bit pe, input bit odd);
        bit8 = b8; parity_en = pe; odd_n_even = odd;
    endtask

    task automatic wr(input logic [7:0] d);
        tx_hold_reg = d;
        webhr = 1'b1;
        @(negedge clk);
        webhr = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input string nm);
        wr(d);
        check({nm, "_txrdy_wr"}, {31'd0, txrdy}, 32'd0);
        @(negedge clk);
        check({nm, "_tx_start"}, {31'd0, tx}, 32'd0);
        check({nm, "_txrdy_ld"}, {31'd0, txrdy}, 32'd1);
    endtask

    task automatic run_frame(output logic [11:0] bits, output int len1, output int len2);
        bits = '0; len1 = 0; len2 = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!tx_busy && !busy2) return;
            if (tx_busy) begin
                len1++;
                if ((i % 16) == 8 && (i / 16) < 12) bits[i / 16] = tx;
            end
            if (busy2) len2++;
            @(negedge clk);
        end
        check("frame_timeout", {30'd0, tx_busy, busy2}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] bits;
        int len1, len2, cnt;

        repeat (3) @(negedge clk);
        check("rst_tx",    {31'd0, tx},      32'd1);
        check("rst_txrdy", {31'd0, txrdy},   32'd1);
        check("rst_busy",  {31'd0, tx_busy}, 32'd0);
        chk_en  = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);

        cfg(1, 0, 0);
        send(8'h55, "8n1");
        run_frame(bits, len1, len2);
        check("8n1_bits", {20'd0, bits}, 32'h2AA);
        check("8n1_len",  len1, 160);
        check("8n2_len",  len2, 176);

        cfg(1, 1, 0);
        send(8'hA3, "8e1");
        run_frame(bits, len1, len2);
        check("8e1_bits", {20'd0, bits}, 32'h546);
        check("8e1_len",  len1, 176);
        check("8e2_len",  len2, 192);

        cfg(1, 1, 1);
        send(8'hA3, "8o1");
        run_frame(bits, len1, len2);
        check("8o1_bits", {20'd0, bits}, 32'h746);

        cfg(0, 0, 0);
        send(8'hFF, "7n1");
        run_frame(bits, len1, len2);
        check("7n1_bits", {20'd0, bits}, 32'h1FE);
        check("7n1_len",  len1, 144);
        check("7n2_len",  len2, 160);

        cfg(0, 1, 0);
        send(8'h80, "7e1");
        run_frame(bits, len1, len2);
        check("7e1_bits", {20'd0, bits}, 32'h200);
        check("7e1_len",  len1, 160);

        // Back-to-back: 0x02 queued behind 0x01, 0x03 arrives while full.
        cfg(1, 0, 0);
        wr(8'h01);
        @(negedge clk);
        check("b2b_txrdy_ld", {31'd0, txrdy}, 32'd1);
        wr(8'h02);
        check("b2b_txrdy_wr", {31'd0, txrdy}, 32'd0);
        wr(8'h03);
        run_frame(bits, len1, len2);
        check("b2b_len",  len1, 318);
        check("b2b_len2", len2, 350);

        // Baud enable held low: the write sits in the holding register.
        baud_clock = 1'b0;
        wr(8'h3C);
        repeat (20) @(negedge clk);
        check("nobaud_tx",    {31'd0, tx},      32'd1);
        check("nobaud_busy",  {31'd0, tx_busy}, 32'd0);
        check("nobaud_txrdy", {31'd0, txrdy},   32'd0);
        cnt = 0;
        for (int i = 0; i < 800; i++) begin
            baud_clock = ((i % 2) == 0);
            @(negedge clk);
            if (tx_busy) cnt++;
        end
        baud_clock = 1'b1;
        check("half_baud_len", cnt, 320);
        check("half_baud_end", {31'd0, tx_busy}, 32'd0);

        // Reset mid-DATA with a second byte pending.
        send(8'hAA, "rst");
        wr(8'h5A);
        repeat (38) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_tx",    {31'd0, tx},      32'd1);
        check("arst_txrdy", {31'd0, txrdy},   32'd1);
        check("arst_busy",  {31'd0, tx_busy}, 32'd0);
        check("arst_tx2",   {31'd0, tx2},     32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_busy || !tx) cnt++;
        end
        check("post_rst_quiet", cnt, 0);

`ifdef UART_TX_BREAK_EN
        cfg(1, 0, 0);
        break_en = 1'b1;
        send(8'hFF, "brk");
        len1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!tx_busy && !busy2) break;
            if (tx_busy) len1++;
            if (i == 50)  check("brk_hold", {31'd0, tx}, 32'd0);
            if (i == 100) break_en = 1'b0;
            if (i == 152) check("brk_stop", {31'd0, tx}, 32'd1);
            @(negedge clk);
        end
        check("brk_len", len1, 160);
`endif

        repeat (5) @(negedge clk);
        check("end_tx2",    {31'd0, tx2},    32'd1);
        check("end_txrdy2", {31'd0, txrdy2}, 32'd1);
        check("end_busy2",  {31'd0, busy2},  32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
